// File: rtl/oam_seq_pkg.sv
// Shared state encoding and OAM geometry for the sprite-load sequencer.
package oam_seq_pkg;

   localparam int unsigned SPR_NUM_W     = 6;
   localparam int unsigned WORDS_PER_SPR = 4;
   localparam int unsigned IDX_W         = $clog2(WORDS_PER_SPR);
   localparam int unsigned OAM_ADDR_W    = SPR_NUM_W + IDX_W;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_e;

endpackage

// File: rtl/oam_seq_watchdog.sv
// Counts consecutive un-acked request cycles and flags expiry on the TIMEOUT-th one.
// Only instantiated when OAM_SEQ_TIMEOUT_EN is defined.
module oam_seq_watchdog #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic active_i,
   input  logic ack_i,
   output logic expire_c
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign expire_c = active_i && !ack_i && (cnt_q == CNT_W'(TIMEOUT - 1));

   // Restart for every word: the count covers one outstanding request only.
   always_comb begin
      cnt_d = cnt_q;
      if (!active_i || ack_i) begin
         cnt_d = '0;
      end else if (!expire_c) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/oam_load_sequencer.sv
// Copies one sprite record from data memory into its OAM slot for the load-sprite instruction.
// Build option OAM_SEQ_TIMEOUT_EN: watchdog on mem_ack that aborts the copy and raises err.
module oam_load_sequencer
   import oam_seq_pkg::*;
#(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_W-1:0]     src_addr,
   input  logic [SPR_NUM_W-1:0]  spr_num,
   output logic                  stall,
   output logic                  busy,
   output logic                  done,
   output logic                  ovf,
   output logic                  err,
   output logic                  mem_req,
   output logic [ADDR_W-1:0]     mem_addr,
   input  logic                  mem_ack,
   input  logic [DATA_W-1:0]     mem_rdata,
   output logic                  oam_we,
   output logic [OAM_ADDR_W-1:0] oam_addr,
   output logic [DATA_W-1:0]     oam_wdata
);

   state_e                state_q, state_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [ADDR_W-1:0]     src_q, src_d;
   logic [SPR_NUM_W-1:0]  spr_q, spr_d;
   logic                  ovf_q, ovf_d;
   logic                  err_q, err_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  mem_req_q, mem_req_d;
   logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
   logic                  oam_we_q, oam_we_d;
   logic [OAM_ADDR_W-1:0] oam_addr_q, oam_addr_d;
   logic [DATA_W-1:0]     oam_wdata_q, oam_wdata_d;
   logic                  expire_c;

`ifdef OAM_SEQ_TIMEOUT_EN
   oam_seq_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk      (clk),
      .rst      (rst),
      .active_i (state_q == REQ),
      .ack_i    (mem_ack),
      .expire_c (expire_c)
   );
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT != 0);
   assign expire_c       = 1'b0;
`endif

   // Stall must cover the launch cycle before the state register moves.
   assign stall     = start | busy_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign ovf       = ovf_q;
   assign err       = err_q;
   assign mem_req   = mem_req_q;
   assign mem_addr  = mem_addr_q;
   assign oam_we    = oam_we_q;
   assign oam_addr  = oam_addr_q;
   assign oam_wdata = oam_wdata_q;

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      src_d       = src_q;
      spr_d       = spr_q;
      ovf_d       = ovf_q;
      err_d       = err_q;
      oam_wdata_d = oam_wdata_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = REQ;
               src_d   = src_addr;
               spr_d   = spr_num;
               idx_d   = '0;
               ovf_d   = 1'b0;
               err_d   = 1'b0;
            end
         end
         REQ: begin
            if (mem_ack) begin
               oam_wdata_d = mem_rdata;
               state_d     = WRITE;
            end else if (expire_c) begin
               err_d   = 1'b1;
               state_d = DONE;
            end
         end
         WRITE: begin
            if (idx_q == IDX_W'(WORDS_PER_SPR - 1)) begin
               state_d = DONE;
            end else begin
               idx_d   = idx_q + IDX_W'(1);
               state_d = REQ;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // A launch while a copy (or its done cycle) is in flight is dropped.
      if (start && (state_q != IDLE)) begin
         ovf_d = 1'b1;
      end

      // Outputs are registered images of the next state.
      busy_d     = (state_d != IDLE);
      done_d     = (state_d == DONE);
      mem_req_d  = (state_d == REQ);
      mem_addr_d = src_d + ADDR_W'(idx_d);
      oam_we_d   = (state_d == WRITE);
      oam_addr_d = {spr_d, idx_d};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         src_q       <= '0;
         spr_q       <= '0;
         ovf_q       <= 1'b0;
         err_q       <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_addr_q  <= '0;
         oam_we_q    <= 1'b0;
         oam_addr_q  <= '0;
         oam_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         src_q       <= src_d;
         spr_q       <= spr_d;
         ovf_q       <= ovf_d;
         err_q       <= err_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         mem_req_q   <= mem_req_d;
         mem_addr_q  <= mem_addr_d;
         oam_we_q    <= oam_we_d;
         oam_addr_q  <= oam_addr_d;
         oam_wdata_q <= oam_wdata_d;
      end
   end

endmodule
